// File: rtl/exu_lsu_pkg.sv
// Shared definitions for the execute-stage load/store data-memory responder:
// access-size encodings, FSM state encoding, byte-lane mask constants and an
// alignment helper used when EXU_LSU_MISALIGN_TRAP_EN is defined.
package exu_lsu_pkg;

  // Access size as issued by the execute stage; 2'b11 is handled as a word.
  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;

  // Byte-lane masks before shifting into position.
  localparam logic [3:0] LSU_MASK_NONE = 4'b0000;
  localparam logic [3:0] LSU_MASK_B    = 4'b0001;
  localparam logic [3:0] LSU_MASK_H    = 4'b0011;
  localparam logic [3:0] LSU_MASK_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // A halfword must sit on an even address, a word on a multiple of four.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic mis;
    case (size)
      LSU_SZ_B: mis = 1'b0;
      LSU_SZ_H: mis = addr_lo[0];
      default:  mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/exu_lsu_load_align.sv
// Combinational load-data alignment: picks the addressed byte or halfword out
// of a 32-bit memory word and sign- or zero-extends it. Word accesses pass
// through untouched. Kept standalone so the fetch path can share it.
module exu_lsu_load_align
  import exu_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select and extension; halfwords use only addr_i[1].
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_v   = rdata_i[7:0];
    half_v   = rdata_i[15:0];
    result_o = rdata_i;
    case (addr_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    if (addr_i[1]) half_v = rdata_i[31:16];
    case (size_i)
      LSU_SZ_B: result_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
      LSU_SZ_H: result_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
      default:  result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/exu_lsu_dmem.sv
// Memory-side responder for execute-stage loads and stores. Takes one request
// at a time, drives a synchronous single-port SRAM with byte-lane write masks,
// and returns extended load data with its destination register.
// Optional macro EXU_LSU_MISALIGN_TRAP_EN: misaligned requests are dropped in
// IDLE and flagged with a one-cycle o_misalign pulse instead of being accessed
// with their low address bits ignored.
module exu_lsu_dmem
  import exu_lsu_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int SRAM_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_mem_wen,
  input  logic               i_mem_ren,
  input  logic [31:0]        i_mem_addr,
  input  logic [31:0]        i_mem_wdata,
  input  logic [1:0]         i_mem_size,
  input  logic               i_mem_unsigned,
  input  logic [4:0]         i_rd_addr,
  output logic               o_busy,
  output logic               o_rdata_vld,
  output logic [31:0]        o_rdata,
  output logic [4:0]         o_rd_addr,
  output logic               o_misalign,
  output logic               o_sram_cs,
  output logic               o_sram_we,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [3:0]         o_sram_wmask,
  output logic [31:0]        o_sram_wdata,
  input  logic [31:0]        i_sram_rdata
);

  // Wait counter spans RD_LAT-1 for RD_LAT in 1..4.
  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  lsu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q;
  logic               rdata_vld_q;
  logic [31:0]        rdata_q;
  logic [4:0]         rd_addr_q;

  // Latched request.
  logic [SRAM_AW+1:0] addr_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic               store_q;
  logic [31:0]        wdata_q;
  logic [4:0]         req_rd_q;

  logic               req_vld;
  logic               req_take;
  logic [31:0]        load_res;
  logic [3:0]         lane_mask;
  logic [31:0]        lane_wdata;
  logic               unused_addr;

  assign req_vld     = i_mem_wen | i_mem_ren;
  assign unused_addr = ^i_mem_addr[31:SRAM_AW+2];

`ifdef EXU_LSU_MISALIGN_TRAP_EN
  logic req_misaligned;
  logic req_trap;
  logic misalign_q;

  assign req_misaligned = lsu_misaligned(i_mem_size, i_mem_addr[1:0]);
  assign req_take = (state_q == ST_IDLE) && req_vld && !req_misaligned;
  assign req_trap = (state_q == ST_IDLE) && req_vld && req_misaligned;

  // One-cycle misalignment pulse in the cycle after the rejected request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= req_trap;
  end

  assign o_misalign = misalign_q;
`else
  assign req_take   = (state_q == ST_IDLE) && req_vld;
  assign o_misalign = 1'b0;
`endif

  // Next-state logic: store finishes after ACCESS, load waits RD_LAT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_take) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (store_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and the registered busy / result-valid flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      rdata_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= (state_d != ST_IDLE);
      rdata_vld_q <= (state_d == ST_RESP);
    end
  end

  // Capture the request when it is accepted in IDLE; a store wins over ren.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      size_q   <= LSU_SZ_B;
      uns_q    <= 1'b0;
      store_q  <= 1'b0;
      wdata_q  <= '0;
      req_rd_q <= '0;
    end else if (req_take) begin
      addr_q   <= i_mem_addr[SRAM_AW+1:0];
      size_q   <= i_mem_size;
      uns_q    <= i_mem_unsigned;
      store_q  <= i_mem_wen;
      wdata_q  <= i_mem_wdata;
      req_rd_q <= i_rd_addr;
    end
  end

  exu_lsu_load_align u_load_align (
    .rdata_i    (i_sram_rdata),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (load_res)
  );

  // Register the aligned load result on the last WAIT cycle; holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      rd_addr_q <= '0;
    end else if (state_q == ST_WAIT && cnt_q == '0) begin
      rdata_q   <= load_res;
      rd_addr_q <= req_rd_q;
    end
  end

  // Lane mask and replicated write data from the latched size and address.
  always_comb begin
    lane_mask  = LSU_MASK_W;
    lane_wdata = wdata_q;
    case (size_q)
      LSU_SZ_B: begin
        lane_mask  = LSU_MASK_B << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      LSU_SZ_H: begin
        lane_mask  = LSU_MASK_H << {addr_q[1], 1'b0};
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask  = LSU_MASK_W;
        lane_wdata = wdata_q;
      end
    endcase
  end

  assign o_sram_cs    = (state_q == ST_ACCESS);
  assign o_sram_we    = o_sram_cs & store_q;
  assign o_sram_wmask = o_sram_we ? lane_mask : LSU_MASK_NONE;
  assign o_sram_addr  = addr_q[SRAM_AW+1:2];
  assign o_sram_wdata = lane_wdata;

  assign o_busy      = busy_q;
  assign o_rdata_vld = rdata_vld_q;
  assign o_rdata     = rdata_q;
  assign o_rd_addr   = rd_addr_q;

endmodule
